// File: rtl/vector_dot_mac.sv
// vector_dot_mac
// Sequential dot-product multiply-accumulate unit. A start request in IDLE
// captures two packed vectors and the mode bits, then one element product
// per clock is added into an internal sum through a single shared
// multiplier. The finished sum is written to the result register c.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a new operation (sampled only in IDLE)
//   signed_mode  1 = two's-complement operands/result, 0 = unsigned
//   accumulate   1 = add to current c, 0 = start from zero
//   a_flat       vector A, element i at [DATA_W*i +: DATA_W]
//   b_flat       vector B, same packing
//   c            result register
//   busy         high while an operation is in progress
//   done         one-cycle completion pulse
//   overflow     sticky accumulation-overflow flag
module vector_dot_mac #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 2 * DATA_W + $clog2(VEC_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      signed_mode,
    input  logic                      accumulate,
    input  logic [VEC_LEN*DATA_W-1:0] a_flat,
    input  logic [VEC_LEN*DATA_W-1:0] b_flat,
    output logic [ACC_W-1:0]          c,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int VEC_W  = VEC_LEN * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [VEC_W-1:0] a_q, a_d;
    logic [VEC_W-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic [DATA_W-1:0] a_elem, b_elem;
    logic [PROD_W-1:0] a_wide, b_wide, prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    add_full;
    logic [ACC_W-1:0]  sum_next;
    logic              add_ovf;
    logic              last_elem;

    // Single shared multiplier: the current element is selected by idx_q.
    // Operands are widened to the full product width first, so the low
    // PROD_W bits of the product are exact in both signed and unsigned mode.
    always_comb begin
        a_elem   = a_q[int'(idx_q) * DATA_W +: DATA_W];
        b_elem   = b_q[int'(idx_q) * DATA_W +: DATA_W];
        a_wide   = {{(PROD_W - DATA_W){signed_q & a_elem[DATA_W-1]}}, a_elem};
        b_wide   = {{(PROD_W - DATA_W){signed_q & b_elem[DATA_W-1]}}, b_elem};
        prod     = a_wide * b_wide;
        prod_ext = {{(ACC_W - PROD_W){signed_q & prod[PROD_W-1]}}, prod};
        add_full = {1'b0, sum_q} + {1'b0, prod_ext};
        sum_next = add_full[ACC_W-1:0];
        // Unsigned overflow is the carry out; signed overflow is two
        // same-sign operands giving a result of the opposite sign.
        if (signed_q) begin
            add_ovf = (sum_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_next[ACC_W-1] != sum_q[ACC_W-1]);
        end else begin
            add_ovf = add_full[ACC_W];
        end
        last_elem = (idx_q == IDX_W'(VEC_LEN - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (last_elem) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath next values
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        signed_d   = signed_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        c_d        = c_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a_flat;
                    b_d      = b_flat;
                    signed_d = signed_mode;
                    idx_d    = '0;
                    sum_d    = accumulate ? c_q : '0;
                    // A fresh (non-accumulating) operation starts a new
                    // overflow history; accumulating keeps it sticky.
                    if (!accumulate) overflow_d = 1'b0;
                end
            end
            MAC: begin
                sum_d = sum_next;
                idx_d = idx_q + IDX_W'(1);
                if (add_ovf) overflow_d = 1'b1;
            end
            FINISH: begin
                c_d    = sum_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            idx_q      <= '0;
            sum_q      <= '0;
            c_q        <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            signed_q   <= signed_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            c_q        <= c_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign c        = c_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_vector_dot_mac.sv
// tb_vector_dot_mac
// Self-checking bench for vector_dot_mac. Directed scenarios plus randomized
// operations are compared against a plain-arithmetic dot-product model.
module tb_vector_dot_mac;

    localparam int DATA_W  = 8;
    localparam int VEC_LEN = 16;
    localparam int ACC_W   = 20;
    localparam int VW      = VEC_LEN * DATA_W;
    localparam longint MOD = 64'sd1 <<< ACC_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic              signed_mode;
    logic              accumulate;
    logic [VW-1:0]     a_flat;
    logic [VW-1:0]     b_flat;
    logic [ACC_W-1:0]  c;
    logic              busy;
    logic              done;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] model_c   = '0;
    logic             model_ovf = 1'b0;

    vector_dot_mac #(
        .DATA_W (DATA_W),
        .VEC_LEN(VEC_LEN),
        .ACC_W  (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .accumulate (accumulate),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .c          (c),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dot product with true integer arithmetic; each partial sum is checked
    // against the representable range of the current mode, then wrapped.
    task automatic model_op(input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input logic sm, input logic acc);
        longint s, p, lo, hi;
        logic [DATA_W-1:0] ea, eb;
        bit f;
        f  = 1'b0;
        lo = sm ? -(MOD / 2) : 0;
        hi = sm ? (MOD / 2) - 1 : MOD - 1;
        if (!acc)    s = 0;
        else if (sm) s = longint'($signed(model_c));
        else         s = longint'(model_c);
        for (int i = 0; i < VEC_LEN; i++) begin
            ea = a[i*DATA_W +: DATA_W];
            eb = b[i*DATA_W +: DATA_W];
            if (sm) p = longint'($signed(ea)) * longint'($signed(eb));
            else    p = longint'(ea) * longint'(eb);
            s = s + p;
            if (s < lo || s > hi) begin
                f = 1'b1;
                s = s & (MOD - 1);
                if (sm && s >= MOD / 2) s = s - MOD;
            end
        end
        model_c   = s[ACC_W-1:0];
        model_ovf = acc ? (model_ovf | f) : f;
    endtask

    function automatic logic [VW-1:0] fill(input logic [DATA_W-1:0] v);
        fill = {VEC_LEN{v}};
    endfunction

    // Issues one start and follows the operation until one cycle past done.
    // disturb pulses start and corrupts a_flat at cycle 5 of the operation.
    task automatic do_op(input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic sm, input logic acc, input bit disturb,
                         output int lat, output int busy_cycles, output int done_cnt);
        a_flat      = a;
        b_flat      = b;
        signed_mode = sm;
        accumulate  = acc;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        lat         = -1;
        busy_cycles = 0;
        done_cnt    = 0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = n;
            end
            if (disturb && n == 5) begin
                start  = 1'b1;
                a_flat = ~a;
            end
            if (disturb && n == 6) start = 1'b0;
            if (lat >= 0 && n >= lat + 1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; signed_mode = 1'b0; accumulate = 1'b0;
        a_flat = '0; b_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (c !== '0)       begin errors++; $display("[TB] FAIL reset_c got %0h expected 0", c); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        do_op(fill(8'd1), fill(8'd2), 1'b0, 1'b0, 1'b0, lat, bc, dc);
        model_op(fill(8'd1), fill(8'd2), 1'b0, 1'b0);
        checks++; if (c !== 20'h00020) begin errors++; $display("[TB] FAIL basic_c got %0h expected 20", c); end
        checks++; if (c !== model_c)   begin errors++; $display("[TB] FAIL basic_model got %0h expected %0h", c, model_c); end
        checks++; if (lat !== VEC_LEN + 1) begin errors++; $display("[TB] FAIL basic_latency got %0d expected %0d", lat, VEC_LEN + 1); end
        checks++; if (bc !== VEC_LEN + 1)  begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d expected %0d", bc, VEC_LEN + 1); end
        checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d expected 1", dc); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf got %b expected 0", overflow); end
    endtask

    task automatic test_unsigned_overflow();
        int lat, bc, dc;
        do_op(fill(8'hFF), fill(8'hFF), 1'b0, 1'b0, 1'b0, lat, bc, dc);
        model_op(fill(8'hFF), fill(8'hFF), 1'b0, 1'b0);
        checks++; if (c !== 20'hFE010) begin errors++; $display("[TB] FAIL umax_c got %0h expected fe010", c); end
        checks++; if (overflow !== 1'b0 || model_ovf !== 1'b0) begin errors++; $display("[TB] FAIL umax_ovf got %b expected 0", overflow); end
        do_op(fill(8'hFF), fill(8'hFF), 1'b0, 1'b1, 1'b0, lat, bc, dc);
        model_op(fill(8'hFF), fill(8'hFF), 1'b0, 1'b1);
        checks++; if (c !== 20'hFC020) begin errors++; $display("[TB] FAIL uacc_c got %0h expected fc020", c); end
        checks++; if (c !== model_c)   begin errors++; $display("[TB] FAIL uacc_model got %0h expected %0h", c, model_c); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL uacc_ovf got %b expected 1", overflow); end
        // Idle cycles must not disturb the held result or flag.
        repeat (3) @(posedge clk);
        #1;
        checks++; if (c !== 20'hFC020 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL hold_c got %0h/%b expected fc020/1", c, overflow); end
    endtask

    task automatic test_signed();
        int lat, bc, dc;
        do_op(fill(8'h80), fill(8'h80), 1'b1, 1'b0, 1'b0, lat, bc, dc);
        model_op(fill(8'h80), fill(8'h80), 1'b1, 1'b0);
        checks++; if (c !== 20'h40000) begin errors++; $display("[TB] FAIL smin_c got %0h expected 40000", c); end
        checks++; if (overflow !== model_ovf) begin errors++; $display("[TB] FAIL smin_ovf got %b expected %b", overflow, model_ovf); end
        do_op(fill(8'hFF), fill(8'h01), 1'b1, 1'b0, 1'b0, lat, bc, dc);
        model_op(fill(8'hFF), fill(8'h01), 1'b1, 1'b0);
        checks++; if (c !== 20'hFFFF0) begin errors++; $display("[TB] FAIL sneg_c got %0h expected ffff0", c); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sneg_ovf got %b expected 0", overflow); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, dc;
        int dones[$];
        do_op(fill(8'd1), fill(8'd2), 1'b0, 1'b0, 1'b0, lat, bc, dc);
        model_op(fill(8'd1), fill(8'd2), 1'b0, 1'b0);
        checks++; if (c !== 20'd32) begin errors++; $display("[TB] FAIL chain0_c got %0d expected 32", c); end
        do_op(fill(8'd1), fill(8'd2), 1'b0, 1'b1, 1'b0, lat, bc, dc);
        model_op(fill(8'd1), fill(8'd2), 1'b0, 1'b1);
        checks++; if (c !== 20'd64) begin errors++; $display("[TB] FAIL chain1_c got %0d expected 64", c); end
        // start held high: a new operation begins on the edge that closes
        // the cycle in which done is visible.
        a_flat = fill(8'd1); b_flat = fill(8'd2);
        signed_mode = 1'b0; accumulate = 1'b1; start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                dones.push_back(n);
                model_op(fill(8'd1), fill(8'd2), 1'b0, 1'b1);
                checks++; if (c !== model_c) begin errors++; $display("[TB] FAIL b2b_c got %0d expected %0d", c, model_c); end
                if (dones.size() == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++; if (dones.size() !== 3) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 3", dones.size()); end
        if (dones.size() == 3) begin
            checks++; if (dones[0] !== VEC_LEN + 1) begin errors++; $display("[TB] FAIL b2b_first got %0d expected %0d", dones[0], VEC_LEN + 1); end
            checks++; if (dones[1] - dones[0] !== VEC_LEN + 2 || dones[2] - dones[1] !== VEC_LEN + 2) begin
                errors++; $display("[TB] FAIL b2b_period got %0d,%0d expected %0d", dones[1] - dones[0], dones[2] - dones[1], VEC_LEN + 2);
            end
        end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stop got busy %b done %b expected 0 0", busy, done); end
    endtask

    task automatic test_ignore_start();
        int lat, bc, dc;
        logic [VW-1:0] ra, rb;
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        do_op(ra, rb, 1'b0, 1'b0, 1'b1, lat, bc, dc);
        model_op(ra, rb, 1'b0, 1'b0);
        checks++; if (c !== model_c) begin errors++; $display("[TB] FAIL ignore_c got %0h expected %0h", c, model_c); end
        checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL ignore_done_count got %0d expected 1", dc); end
        checks++; if (lat !== VEC_LEN + 1) begin errors++; $display("[TB] FAIL ignore_latency got %0d expected %0d", lat, VEC_LEN + 1); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, dc;
        int seen_done;
        a_flat = fill(8'd7); b_flat = fill(8'd9);
        signed_mode = 1'b0; accumulate = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_c = '0; model_ovf = 1'b0;
        checks++; if (c !== '0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset got c %0h busy %b done %b ovf %b expected 0 0 0 0", c, busy, done, overflow);
        end
        seen_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
            if (n == 2) rst = 1'b0;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("[TB] FAIL midreset_done got %0d expected 0", seen_done); end
        do_op(fill(8'd1), fill(8'd2), 1'b0, 1'b1, 1'b0, lat, bc, dc);
        model_op(fill(8'd1), fill(8'd2), 1'b0, 1'b1);
        checks++; if (c !== 20'd32 || c !== model_c) begin errors++; $display("[TB] FAIL after_reset_c got %0d expected 32", c); end
    endtask

    task automatic test_random();
        int lat, bc, dc;
        logic [VW-1:0] ra, rb;
        logic sm, acc;
        for (int k = 0; k < 24; k++) begin
            ra  = {$urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom};
            sm  = 1'($urandom_range(0, 1));
            acc = 1'($urandom_range(0, 1));
            do_op(ra, rb, sm, acc, 1'b0, lat, bc, dc);
            model_op(ra, rb, sm, acc);
            checks++; if (c !== model_c) begin errors++; $display("[TB] FAIL rand_c[%0d] got %0h expected %0h", k, c, model_c); end
            checks++; if (overflow !== model_ovf) begin errors++; $display("[TB] FAIL rand_ovf[%0d] got %b expected %b", k, overflow, model_ovf); end
            checks++; if (lat !== VEC_LEN + 1 || dc !== 1) begin errors++; $display("[TB] FAIL rand_timing[%0d] got lat %0d dones %0d expected %0d 1", k, lat, dc, VEC_LEN + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unsigned_overflow();
        test_signed();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
